// File: rtl/awgn_fmt_pkg.sv
// Fixed-point format constants shared by the AWGN sqrt unit and its square-back checker.
// Also holds the checker FSM encoding, the result payload and the rounding-bias helper.
package awgn_fmt_pkg;

    localparam int unsigned FW       = 17;             // f width, u<17,13>
    localparam int unsigned FF       = 13;
    localparam int unsigned EW       = 31;             // e width, u<31,24>
    localparam int unsigned EF       = 24;
    localparam int unsigned SH       = 2 * FF - EF;    // shift from f^2 scale to e scale
    localparam int unsigned AW       = 2 * FW;         // full product width
    localparam int unsigned PW       = AW + 1;         // product plus rounding carry
    localparam int unsigned CW       = $clog2(FW);     // multiplier step counter width
    localparam int unsigned TOL_DEF  = 1024;           // default pass tolerance in e LSBs

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_e;

    typedef struct packed {
        logic [EW-1:0] sq;
        logic [EW-1:0] err;
        logic          sat;
        logic          pass;
    } chk_res_t;

    // Half-up bias added before the SH-bit right shift; zero when no bits are dropped.
    function automatic logic [PW-1:0] round_bias();
        if (SH == 0) begin
            return '0;
        end
        return PW'(1) << (SH - 1);
    endfunction

endpackage

// File: rtl/seq_sq_mul.sv
// Radix-2 shift-add squarer: one conditional add per cycle, LSB first, fixed FW steps.
module seq_sq_mul
    import awgn_fmt_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [FW-1:0] op_in,
    output logic          done,
    output logic [AW-1:0] acc
);

    logic [AW-1:0] mcand_q,  mcand_d;
    logic [FW-1:0] mplier_q, mplier_d;
    logic [AW-1:0] acc_q,    acc_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;

    // The multiplicand shifts left as the multiplier shifts right, so step i adds op<<i when bit i is set.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start) begin
            mcand_d  = AW'(op_in);
            mplier_d = op_in;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == CW'(FW - 1)) begin
                cnt_d  = '0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;
    assign acc  = acc_q;

endmodule

// File: rtl/sqrt_square_check.sv
// Squares a sqrt result back into e format, rounds/saturates it and compares against the original e.
// One sample in flight; valid/ready on both sides.
module sqrt_square_check
    import awgn_fmt_pkg::*;
#(
    parameter int unsigned TOL = TOL_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [FW-1:0] f_in,
    input  logic [EW-1:0] e_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] sq_out,
    output logic [EW-1:0] err_out,
    output logic          sat,
    output logic          pass
);

    chk_state_e    state_q,     state_d;
    logic          in_ready_q,  in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [EW-1:0] e_q,         e_d;
    chk_res_t      res_q,       res_d;

    logic          accept_c;
    logic          mul_done_c;
    logic [AW-1:0] acc_c;
    logic [PW-1:0] rnd_sum_c;
    logic [PW-1:0] rnd_q_c;
    chk_res_t      round_res_c;

    assign accept_c = in_valid && in_ready_q;

    seq_sq_mul u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (accept_c),
        .op_in (f_in),
        .done  (mul_done_c),
        .acc   (acc_c)
    );

    // Round half-up to e scale, clamp to the e range, then take the absolute difference.
    always_comb begin
        rnd_sum_c       = PW'(acc_c) + round_bias();
        rnd_q_c         = rnd_sum_c >> SH;
        round_res_c.sat = |rnd_q_c[PW-1:EW];
        round_res_c.sq  = round_res_c.sat ? {EW{1'b1}} : rnd_q_c[EW-1:0];
        if (round_res_c.sq >= e_q) begin
            round_res_c.err = round_res_c.sq - e_q;
        end else begin
            round_res_c.err = e_q - round_res_c.sq;
        end
        round_res_c.pass = (round_res_c.err <= EW'(TOL)) && !round_res_c.sat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept_c)   state_d = ST_MUL;
            ST_MUL:   if (mul_done_c) state_d = ST_ROUND;
            ST_ROUND:                 state_d = ST_DONE;
            ST_DONE:  if (out_ready)  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Handshake flags follow the next state so they line up with the state register.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        e_d         = e_q;
        res_d       = res_q;
        if (accept_c) begin
            e_d = e_in;
        end
        if (state_q == ST_ROUND) begin
            res_d = round_res_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            e_q         <= '0;
            res_q       <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            e_q         <= e_d;
            res_q       <= res_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sq_out    = res_q.sq;
    assign err_out   = res_q.err;
    assign sat       = res_q.sat;
    assign pass      = res_q.pass;

endmodule

// File: tb/tb_sqrt_square_check.sv
// Scoreboard bench for sqrt_square_check: arithmetic reference model, random stimulus and backpressure.
module tb_sqrt_square_check;

    localparam longint unsigned E_MAX   = 64'h7FFF_FFFF;
    localparam longint unsigned TOL_V   = 1024;
    localparam int              LAT     = 20;   // accept-negedge to first-valid-negedge, in cycles
    localparam int              STALL_I = 1;    // result index held for 10 cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] f_in = '0;
    logic [30:0] e_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [30:0] sq_out;
    logic [30:0] err_out;
    logic        sat;
    logic        pass;

    always #5 clk = ~clk;

    sqrt_square_check dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f_in      (f_in),
        .e_in      (e_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sq_out    (sq_out),
        .err_out   (err_out),
        .sat       (sat),
        .pass      (pass)
    );

    typedef struct {
        logic [30:0] sq;
        logic [30:0] err;
        logic        sat;
        logic        pass;
    } exp_t;

    exp_t exp_q[$];
    int   acc_cyc_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // f^2 rescaled from 2*13 to 24 fraction bits with half-up rounding, clamped to 31 bits.
    function automatic exp_t model(input logic [16:0] f, input logic [30:0] e);
        exp_t r;
        longint unsigned fv, q, ev;
        fv = 64'(f);
        ev = 64'(e);
        q  = (fv * fv + 2) / 4;
        r.sat = (q > E_MAX);
        if (r.sat) q = E_MAX;
        r.sq   = 31'(q);
        r.err  = 31'((q > ev) ? (q - ev) : (ev - q));
        r.pass = (64'(r.err) <= TOL_V) && !r.sat;
        return r;
    endfunction

    // Monitor: pops the scoreboard on each new result, checks latency and hold-stability.
    bit          prev_v = 0;
    bit          stall_prev = 0;
    logic [30:0] s_sq, s_err;
    logic        s_sat, s_pass;

    always @(negedge clk) begin
        exp_t x;
        int   a;
        if (rst) begin
            prev_v     = 0;
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_sq",    64'(sq_out),    64'(s_sq));
                chk("hold_err",   64'(err_out),   64'(s_err));
                chk("hold_flags", 64'({sat, pass}), 64'({s_sat, s_pass}));
            end
            if (out_valid) begin
                chk("in_ready_while_valid", 64'(in_ready), 64'd0);
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out: got out_valid=1 expected no result (cycle %0d)", cyc);
                    end else begin
                        x = exp_q.pop_front();
                        a = acc_cyc_q.pop_front();
                        chk("latency", 64'(cyc - a), 64'(LAT));
                        chk("sq_out",  64'(sq_out),  64'(x.sq));
                        chk("err_out", 64'(err_out), 64'(x.err));
                        chk("sat",     64'(sat),     64'(x.sat));
                        chk("pass",    64'(pass),    64'(x.pass));
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            if (stall_prev) begin
                s_sq   = sq_out;
                s_err  = err_out;
                s_sat  = sat;
                s_pass = pass;
            end
            prev_v = out_valid;
        end
    end

    // Sink: random backpressure, plus one long 10-cycle hold on a chosen result.
    initial begin
        int idx  = 0;
        int hold = 0;
        bit pv   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                out_ready = 1'b0;
                pv        = 0;
                hold      = 0;
            end else begin
                if (out_valid && !pv) begin
                    if (idx == STALL_I) hold = 10;
                    idx++;
                end
                pv = out_valid;
                if (hold > 0) begin
                    out_ready = 1'b0;
                    hold--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        end
    end

    task automatic send(input logic [16:0] f, input logic [30:0] e, input bit expect_it, input bit gaps);
        bit got = 0;
        @(posedge clk);
        #1;
        f_in     = f;
        e_in     = e;
        in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
        end else if (expect_it) begin
            exp_q.push_back(model(f, e));
            acc_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        f_in     = 17'($urandom);
        e_in     = 31'($urandom);
        if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_random(input int n);
        logic [16:0] f;
        logic [30:0] e;
        longint      m;
        for (int i = 0; i < n; i++) begin
            f = 17'($urandom);
            if ($urandom_range(0, 2) == 0) f = 17'($urandom_range(0, 8191));
            if ($urandom_range(0, 1) == 0) begin
                e = 31'($urandom);
            end else begin
                m = longint'(model(f, 31'd0).sq) + longint'($urandom_range(0, 2100)) - 1050;
                if (m < 0) m = 0;
                if (m > longint'(E_MAX)) m = longint'(E_MAX);
                e = 31'(m);
            end
            send(f, e, 1, 1);
        end
    endtask

    initial begin
        int bad;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sq_out",    64'(sq_out),    64'd0);
        chk("rst_err_out",   64'(err_out),   64'd0);
        chk("rst_flags",     64'({sat, pass}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(17'h02000, 31'h1000000, 1, 1);
        send(17'd1,     31'd0,       1, 1);
        send(17'd2,     31'd0,       1, 1);
        send(17'd3,     31'd0,       1, 0);
        send(17'h1FFFF, 31'h7FFFFFFF, 1, 1);
        send(17'h02000, 31'h1000400, 1, 1);
        send(17'h02000, 31'h1000401, 1, 1);
        send(17'd0,     31'd5,       1, 0);
        send(17'h16A0A, 31'h0,       1, 1);
        send_random(40);
        drain();

        // Abort a sample mid-multiply: it must never produce a result.
        send(17'h1ABCD, 31'h1234567, 0, 0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready",  64'(in_ready),  64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("abort_no_result", 64'(bad), 64'd0);
        chk("abort_idle_ready", 64'(in_ready), 64'd1);

        send(17'h02000, 31'h1000000, 1, 1);
        send_random(10);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
